tlb_replace_ctrl: RTL

//  Stateful replacement controller for a fully-associative TLB/PTE cache of ENTRIES slots.

---
 rtl/tlb_repl_pkg.sv | 63 ++++++
 rtl/plru_tree.sv | 29 ++
 rtl/tlb_replace_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/tlb_repl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlb_repl_pkg
// Brief    : Shared types and tree-PLRU helper functions for the TLB
//            replacement controller. The walk/touch helpers operate on a
//            maximum-size tree vector so any ENTRIES from 2 to 64 can use them.
// Revision : 1.0 - initial release
// ============================================================================
package tlb_repl_pkg;

  localparam int unsigned c_ENTRIES_DEF = 8;
  localparam int unsigned c_MAX_IDX_W   = 6;
  localparam int unsigned c_MAX_NODES   = 63;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } repl_state_e;

  // Slot index width for a given slot count.
  function automatic int unsigned idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  // Follow the tree bits from the root down to a leaf; the leaf heap number
  // minus the slot count is the victim slot.
  function automatic logic [c_MAX_IDX_W-1:0] plru_walk(
    input logic [c_MAX_NODES-1:0] tree,
    input int unsigned            iw
  );
    int unsigned n;
    n = 1;
    for (int unsigned d = 0; d < c_MAX_IDX_W; d++) begin
      if (d < iw) begin
        n = (n << 1) | {31'b0, tree[n-1]};
      end
    end
    return c_MAX_IDX_W'(n - (32'd1 << iw));
  endfunction

  // Point every node on the path to slot idx away from that slot.
  function automatic logic [c_MAX_NODES-1:0] plru_touch(
    input logic [c_MAX_NODES-1:0] tree,
    input logic [c_MAX_IDX_W-1:0] idx,
    input int unsigned            iw
  );
    logic [c_MAX_NODES-1:0] t;
    int unsigned            n;
    logic                   dir;
    t = tree;
    n = 1;
    for (int unsigned d = 0; d < c_MAX_IDX_W; d++) begin
      if (d < iw) begin
        dir      = idx[iw-1-d];
        t[n-1]   = ~dir;
        n        = (n << 1) | {31'b0, dir};
      end
    end
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/plru_tree.sv
`default_nettype none
// ============================================================================
// Module   : plru_tree
// Brief    : Pure combinational tree-PLRU slice: reports the victim of the
//            incoming tree and the tree after touching i_touch_idx.
// Revision : 1.0 - initial release
// ============================================================================
module plru_tree
  import tlb_repl_pkg::*;
#(
  parameter  int unsigned ENTRIES = c_ENTRIES_DEF,
  localparam int unsigned IDX_W   = idx_w(ENTRIES),
  localparam int unsigned NODES   = ENTRIES - 1
) (
  input  logic [NODES-1:0] i_tree,
  input  logic [IDX_W-1:0] i_touch_idx,
  output logic [IDX_W-1:0] o_victim_idx,
  output logic [NODES-1:0] o_next_tree
);

  // Widen to the package's maximum tree size, evaluate, and narrow back.
  always_comb begin
    o_victim_idx = IDX_W'(plru_walk(c_MAX_NODES'(i_tree), IDX_W));
    o_next_tree  = NODES'(plru_touch(c_MAX_NODES'(i_tree),
                                     c_MAX_IDX_W'(i_touch_idx), IDX_W));
  end

endmodule
`default_nettype wire

// File: rtl/tlb_replace_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tlb_replace_ctrl
// Brief    : Replacement controller for a fully-associative TLB. Owns the
//            per-slot valid bits and tree-PLRU state, grants victim slots
//            (lowest invalid slot first, else the PLRU victim) and applies
//            single-slot and global flushes.
//            Optional feature macro: ENTRY_LOCK_EN (adds lock_mask/alloc_err).
// Revision : 1.0 - initial release
// ============================================================================
module tlb_replace_ctrl
  import tlb_repl_pkg::*;
#(
  parameter  int unsigned ENTRIES = c_ENTRIES_DEF,
  localparam int unsigned IDX_W   = idx_w(ENTRIES),
  localparam int unsigned NODES   = ENTRIES - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               touch_valid,
  input  logic [IDX_W-1:0]   touch_idx,
  input  logic               alloc_req,
  output logic               alloc_ready,
  output logic               alloc_ack,
  output logic [IDX_W-1:0]   alloc_idx,
  output logic               alloc_evict,
  input  logic               flush_all,
  input  logic               flush_valid,
  input  logic [IDX_W-1:0]   flush_idx,
  output logic [ENTRIES-1:0] valid,
  output logic [NODES-1:0]   plru_state
`ifdef ENTRY_LOCK_EN
  ,
  input  logic [ENTRIES-1:0] lock_mask,
  output logic               alloc_err
`endif
);

  repl_state_e        r_state, w_state_next;
  logic [ENTRIES-1:0] r_valid, w_valid_next;
  logic [NODES-1:0]   r_plru, w_plru_next;
  logic               r_ack, r_evict;
  logic [IDX_W-1:0]   r_idx;
  logic               w_grant, w_commit, w_err;
  logic [IDX_W-1:0]   w_victim, w_plru_victim, w_free_idx;
  logic               w_free_any;
  logic [NODES-1:0]   w_touch_tree, w_lookup_tree, w_alloc_tree;
  logic [IDX_W-1:0]   w_unused_alloc_victim;

  // Lookup touch is evaluated on the current tree; its victim is the PLRU pick.
  plru_tree #(.ENTRIES(ENTRIES)) u_tree_lookup (
    .i_tree       (r_plru),
    .i_touch_idx  (touch_idx),
    .o_victim_idx (w_plru_victim),
    .o_next_tree  (w_touch_tree)
  );

  assign w_lookup_tree = touch_valid ? w_touch_tree : r_plru;

  // Alloc touch is chained after the lookup touch so shared nodes follow the alloc.
  plru_tree #(.ENTRIES(ENTRIES)) u_tree_alloc (
    .i_tree       (w_lookup_tree),
    .i_touch_idx  (w_victim),
    .o_victim_idx (w_unused_alloc_victim),
    .o_next_tree  (w_alloc_tree)
  );

  // Lowest-index invalid slot.
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

`ifdef ENTRY_LOCK_EN
  logic [ENTRIES-1:0] w_elig;
  logic               w_elig_any;
  logic [IDX_W-1:0]   w_elig_idx;

  assign w_elig = ~(lock_mask & r_valid);

  // Lowest-index slot that is not both locked and valid.
  always_comb begin
    w_elig_any = 1'b0;
    w_elig_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_elig_any = 1'b1;
        w_elig_idx = IDX_W'(i);
      end
    end
  end

  // Victim choice: free slot, else unlocked PLRU victim, else lowest unlocked.
  always_comb begin
    w_err    = 1'b0;
    w_victim = w_plru_victim;
    if (w_free_any) begin
      w_victim = w_free_idx;
    end else if (w_elig[w_plru_victim]) begin
      w_victim = w_plru_victim;
    end else if (w_elig_any) begin
      w_victim = w_elig_idx;
    end else begin
      w_err = 1'b1;
    end
  end
`else
  // Victim choice: free slot first, else the PLRU victim.
  always_comb begin
    w_err    = 1'b0;
    w_victim = w_free_any ? w_free_idx : w_plru_victim;
  end
`endif

  // FSM next state; a grant is only possible from IDLE.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    alloc_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        alloc_ready = 1'b1;
        if (alloc_req) begin
          w_grant      = 1'b1;
          w_state_next = ACK;
        end
      end
      ACK:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_commit = w_grant & ~w_err;

  // Valid update with priority flush_all > flush_valid > alloc set.
  always_comb begin
    w_valid_next = r_valid;
    if (w_commit) begin
      w_valid_next[w_victim] = 1'b1;
    end
    if (flush_valid) begin
      w_valid_next[flush_idx] = 1'b0;
    end
    if (flush_all) begin
`ifdef ENTRY_LOCK_EN
      w_valid_next = w_valid_next & lock_mask;
`else
      w_valid_next = '0;
`endif
    end
  end

  // PLRU update: lookup touch, then the alloc touch on top of it.
  always_comb begin
    w_plru_next = w_commit ? w_alloc_tree : w_lookup_tree;
  end

  // State, valid, PLRU and grant registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_plru  <= '0;
      r_ack   <= 1'b0;
      r_idx   <= '0;
      r_evict <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_valid_next;
      r_plru  <= w_plru_next;
      r_ack   <= w_grant;
      if (w_grant) begin
        r_idx   <= w_victim;
        r_evict <= w_commit & r_valid[w_victim];
      end
    end
  end

`ifdef ENTRY_LOCK_EN
  logic r_err;

  // Error flag accompanies an ack when no slot could be granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_grant & w_err;
    end
  end

  assign alloc_err = r_err;
`endif

  assign alloc_ack   = r_ack;
  assign alloc_idx   = r_idx;
  assign alloc_evict = r_evict;
  assign valid       = r_valid;
  assign plru_state  = r_plru;

endmodule
`default_nettype wire
